// File: rtl/time_pkg.sv
// Shared field layout, limits and FSM encoding for the time-of-day blocks.
package time_pkg;

  localparam int MIL_LSB  = 24;
  localparam int HOUR_LSB = 16;
  localparam int MIN_LSB  = 8;
  localparam int SEC_LSB  = 0;

  localparam logic [7:0] SEC_MAX    = 8'd59;
  localparam logic [7:0] MIN_MAX    = 8'd59;
  localparam logic [7:0] HOUR24_MAX = 8'd23;
  localparam logic [7:0] HOUR12_MAX = 8'd12;

  localparam int MIL_24H = 0;
  localparam int MIL_PM  = 1;

  // 24h mode, 00:00:00
  localparam logic [31:0] TIME_RST = 32'h0100_0000;

  typedef enum logic [1:0] {IDLE, SNAP, SEND, DONE} state_t;

endpackage

// File: rtl/bin2bcd8.sv
// Binary byte to packed two-digit BCD; only built when TIME_READER_BCD_EN is defined.
`ifdef TIME_READER_BCD_EN
module bin2bcd8 (
  input  logic [7:0] bin_i,
  output logic [7:0] bcd_o
);

  always_comb begin
    bcd_o = (((bin_i / 8'd10) % 8'd10) << 4) | (bin_i % 8'd10);
  end

endmodule
`endif

// File: rtl/time_advance.sv
// Combinational one-second advance of a {mil, hour, minute, second} word.
module time_advance
  import time_pkg::*;
(
  input  logic [31:0] time_i,
  output logic [31:0] time_o
);

  logic [7:0] mil, hour, minute, second;
  logic [7:0] mil_n, hour_n, min_n, sec_n;

  always_comb begin
    mil    = time_i[MIL_LSB  +: 8];
    hour   = time_i[HOUR_LSB +: 8];
    minute = time_i[MIN_LSB  +: 8];
    second = time_i[SEC_LSB  +: 8];
    mil_n  = mil;
    hour_n = hour;
    min_n  = minute;
    sec_n  = second + 8'd1;
    // Out-of-range loaded fields wrap the same way their maximum does.
    if (second >= SEC_MAX) begin
      sec_n = 8'd0;
      min_n = minute + 8'd1;
      if (minute >= MIN_MAX) begin
        min_n = 8'd0;
        if (mil[MIL_24H]) begin
          hour_n = (hour >= HOUR24_MAX) ? 8'd0 : hour + 8'd1;
        end else if (hour >= HOUR12_MAX) begin
          hour_n = 8'd1;
        end else begin
          hour_n = hour + 8'd1;
          if (hour == HOUR12_MAX - 8'd1) mil_n[MIL_PM] = ~mil[MIL_PM];
        end
      end
    end
    time_o = {mil_n, hour_n, min_n, sec_n};
  end

endmodule

// File: rtl/time_reader.sv
// Running time-of-day counter with a snapshot byte-stream readout.
// Optional: TIME_READER_BCD_EN sends hour/minute/second bytes as packed BCD.
module time_reader
  import time_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_in,
  input  logic        load,
  input  logic        tick_en,
  input  logic        rd_req,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [1:0]  byte_idx,
  output logic        busy,
  output logic        done,
  output logic [31:0] time_now
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [31:0]   time_q, time_d, time_adv;
  logic [PW-1:0] presc_q, presc_d;

  time_advance u_advance (
    .time_i (time_q),
    .time_o (time_adv)
  );

  // Counter stage: load has priority and drops a coincident tick.
  always_comb begin
    time_d  = time_q;
    presc_d = presc_q;
    if (load) begin
      time_d  = time_in;
      presc_d = '0;
    end else if (tick_en) begin
      if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
        presc_d = '0;
        time_d  = time_adv;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q  <= TIME_RST;
      presc_q <= '0;
    end else begin
      time_q  <= time_d;
      presc_q <= presc_d;
    end
  end

  state_t      state_q;
  logic [31:0] shadow_q;
  logic [7:0]  byte_out_q;
  logic        byte_valid_q, busy_q, done_q;
  logic [1:0]  byte_idx_q;

  logic [31:0] sel_word;
  logic [1:0]  sel_idx;
  logic [7:0]  raw_byte, fmt_byte;

  // Byte that will be presented next: first byte comes straight from the
  // committing counter value so SNAP and the first SEND cycle agree.
  always_comb begin
    sel_word = (state_q == SNAP) ? time_d : shadow_q;
    sel_idx  = (state_q == SNAP) ? 2'd0 : byte_idx_q + 2'd1;
    case (sel_idx)
      2'd0:    raw_byte = sel_word[MIL_LSB  +: 8];
      2'd1:    raw_byte = sel_word[HOUR_LSB +: 8];
      2'd2:    raw_byte = sel_word[MIN_LSB  +: 8];
      default: raw_byte = sel_word[SEC_LSB  +: 8];
    endcase
  end

`ifdef TIME_READER_BCD_EN
  logic [7:0] bcd_byte;

  bin2bcd8 u_bcd (
    .bin_i (raw_byte),
    .bcd_o (bcd_byte)
  );

  assign fmt_byte = (sel_idx == 2'd0) ? raw_byte : bcd_byte;
`else
  assign fmt_byte = raw_byte;
`endif

  always_ff @(posedge clk) begin
    if (state_q == SNAP) shadow_q <= time_d;
  end

  // Readout FSM stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_out_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      byte_idx_q   <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            state_q <= SNAP;
            busy_q  <= 1'b1;
          end
        end
        SNAP: begin
          state_q      <= SEND;
          byte_idx_q   <= 2'd0;
          byte_out_q   <= fmt_byte;
          byte_valid_q <= 1'b1;
        end
        SEND: begin
          if (byte_valid_q && byte_ready) begin
            if (byte_idx_q == 2'd3) begin
              state_q      <= DONE;
              byte_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              byte_out_q <= fmt_byte;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_idx   = byte_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign time_now   = time_q;

endmodule

// File: tb/tb_time_reader.sv
// Self-checking bench for time_reader against a field-level clock model.
module tb_time_reader;

  localparam int TPS = 1;

  logic        clk = 1'b0;
  logic        rst, load, tick_en, rd_req, byte_ready;
  logic [31:0] time_in;
  logic [7:0]  byte_out;
  logic        byte_valid, busy, done;
  logic [1:0]  byte_idx;
  logic [31:0] time_now;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [31:0] mdl_time;
  int          mdl_presc;

  time_reader #(.TICKS_PER_SEC(TPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .time_in    (time_in),
    .load       (load),
    .tick_en    (tick_en),
    .rd_req     (rd_req),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_idx   (byte_idx),
    .busy       (busy),
    .done       (done),
    .time_now   (time_now)
  );

  always #5 clk = ~clk;

  // Clock-of-day rules applied field by field.
  function automatic logic [31:0] m_adv(input logic [31:0] t);
    int mil, hr, mn, sc;
    mil = int'(t[31:24]); hr = int'(t[23:16]); mn = int'(t[15:8]); sc = int'(t[7:0]);
    if (sc >= 59) begin
      sc = 0;
      if (mn >= 59) begin
        mn = 0;
        if (mil % 2 == 1) hr = (hr >= 23) ? 0 : hr + 1;
        else if (hr >= 12) hr = 1;
        else if (hr == 11) begin hr = 12; mil = mil ^ 2; end
        else hr = hr + 1;
      end else mn = mn + 1;
    end else sc = sc + 1;
    return {8'(mil), 8'(hr), 8'(mn), 8'(sc)};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] snap, input int k);
    logic [7:0] b;
    b = 8'(snap >> (8 * (3 - k)));
`ifdef TIME_READER_BCD_EN
    if (k != 0) b = 8'(((b / 10) % 10) * 16 + (b % 10));
`endif
    return b;
  endfunction

  task automatic cyc();
    logic [31:0] nt;
    int np;
    nt = mdl_time; np = mdl_presc;
    if (rst) begin nt = 32'h0100_0000; np = 0; end
    else if (load) begin nt = time_in; np = 0; end
    else if (tick_en) begin
      if (mdl_presc == TPS - 1) begin np = 0; nt = m_adv(mdl_time); end
      else np = mdl_presc + 1;
    end
    @(posedge clk); #1;
    mdl_time = nt; mdl_presc = np;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic do_load(input logic [31:0] v);
    time_in = v; load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic do_tick();
    tick_en = 1'b1; cyc(); tick_en = 1'b0;
  endtask

  task automatic readout(input int stall_idx, input int stall_n, input bit tick_stall,
                         input bit rdreq_mid, output logic [31:0] stream);
    logic [31:0] snap;
    stream = '0;
    rd_req = 1'b1; byte_ready = 1'b1; cyc(); rd_req = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || byte_valid !== 1'b0) begin
      n_fail++; $display("FAIL snap_cycle busy=%b valid=%b want busy=1 valid=0", busy, byte_valid);
    end
    cyc();
    snap = mdl_time;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (byte_valid !== 1'b1 || byte_idx !== 2'(i) || byte_out !== exp_byte(snap, i)) begin
        n_fail++;
        $display("FAIL stream_byte%0d valid=%b idx=%0d out=%h want valid=1 idx=%0d out=%h",
                 i, byte_valid, byte_idx, byte_out, i, exp_byte(snap, i));
      end
      stream = {stream[23:0], byte_out};
      if (i == stall_idx) begin
        byte_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick_en = tick_stall && (k == 0); rd_req = rdreq_mid;
          cyc();
          tick_en = 1'b0; rd_req = 1'b0;
          n_tests++;
          if (byte_valid !== 1'b1 || byte_idx !== 2'(i) || byte_out !== exp_byte(snap, i)) begin
            n_fail++;
            $display("FAIL stall_hold%0d valid=%b idx=%0d out=%h want valid=1 idx=%0d out=%h",
                     k, byte_valid, byte_idx, byte_out, i, exp_byte(snap, i));
          end
        end
        n_tests++;
        if (time_now !== mdl_time) begin
          n_fail++; $display("FAIL stall_time got %h want %h", time_now, mdl_time);
        end
        byte_ready = 1'b1;
      end
      cyc();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle done=%b busy=%b valid=%b want 1,0,0", done, busy, byte_valid);
    end
    cyc();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_width done=%b want 0", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc();
    n_tests++;
    if (time_now !== 32'h0100_0000) begin
      n_fail++; $display("FAIL reset_time got %h want 01000000", time_now);
    end
    n_tests++;
    if ({byte_out, byte_valid, byte_idx, busy, done} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl out=%h valid=%b idx=%0d busy=%b done=%b want all 0",
               byte_out, byte_valid, byte_idx, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_readout_basic();
    logic [31:0] s;
    readout(-1, 0, 1'b0, 1'b0, s);
    n_tests++;
    if (s !== 32'h0100_0000) begin
      n_fail++; $display("FAIL basic_stream got %h want 01000000", s);
    end
  endtask

  task automatic test_rollover();
    do_load(32'h0117_3B3B); do_tick();
    n_tests++;
    if (time_now !== 32'h0100_0000 || time_now !== mdl_time) begin
      n_fail++; $display("FAIL roll_24h got %h want 01000000", time_now);
    end
    do_load(32'h000B_3B3B); do_tick();
    n_tests++;
    if (time_now !== 32'h020C_0000) begin
      n_fail++; $display("FAIL roll_11_12 got %h want 020c0000", time_now);
    end
    do_load(32'h020C_3B3B); do_tick();
    n_tests++;
    if (time_now !== 32'h0201_0000) begin
      n_fail++; $display("FAIL roll_12_1 got %h want 02010000", time_now);
    end
  endtask

  task automatic test_random();
    logic [31:0] s;
    for (int c = 0; c < 400; c++) begin
      load = ($urandom % 12) == 0;
      tick_en = $urandom % 2;
      time_in = {8'($urandom), 8'($urandom_range(0, 30)), 8'($urandom_range(57, 63)),
                 8'($urandom_range(55, 63))};
      cyc();
      n_tests++;
      if (time_now !== mdl_time) begin
        n_fail++; $display("FAIL random_time cyc%0d got %h want %h", c, time_now, mdl_time);
      end
    end
    load = 1'b0; tick_en = 1'b0;
    for (int r = 0; r < 4; r++) begin
      do_load({8'($urandom), 8'($urandom_range(0, 23)), 8'($urandom_range(0, 59)),
               8'($urandom_range(0, 59))});
      readout($urandom_range(0, 3), $urandom_range(1, 4), 1'b1, 1'b0, s);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s;
    do_load(32'h0109_1E3B);
    readout(1, 3, 1'b1, 1'b0, s);
  endtask

  task automatic test_load_tick_same();
    time_in = 32'h0105_0A14; load = 1'b1; tick_en = 1'b1; cyc();
    load = 1'b0; tick_en = 1'b0;
    n_tests++;
    if (time_now !== 32'h0105_0A14) begin
      n_fail++; $display("FAIL load_tick got %h want 01050a14", time_now);
    end
    do_tick();
    n_tests++;
    if (time_now !== mdl_time) begin
      n_fail++; $display("FAIL tick_after_load got %h want %h", time_now, mdl_time);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    int d0;
    d0 = done_cnt;
    readout(2, 2, 1'b0, 1'b1, s);
    for (int k = 0; k < 5; k++) cyc();
    n_tests++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rdreq_busy dones=%0d busy=%b want 1 done, busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_rst_mid();
    int d0;
    do_load(32'h0105_0A14);
    rd_req = 1'b1; byte_ready = 1'b1; cyc(); rd_req = 1'b0;
    cyc(); cyc(); cyc();
    n_tests++;
    if (byte_valid !== 1'b1 || byte_idx !== 2'd2) begin
      n_fail++; $display("FAIL rst_setup valid=%b idx=%0d want 1,2", byte_valid, byte_idx);
    end
    d0 = done_cnt;
    rst = 1'b1; cyc(); rst = 1'b0;
    n_tests++;
    if (byte_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || time_now !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL rst_mid valid=%b busy=%b done=%b time=%h want 0,0,0,01000000",
               byte_valid, busy, done, time_now);
    end
    for (int k = 0; k < 6; k++) cyc();
    n_tests++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_done dones=%0d busy=%b want 0 dones, busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_bcd();
    logic [31:0] s;
    logic [7:0]  want;
`ifdef TIME_READER_BCD_EN
    want = 8'h45;
`else
    want = 8'h2D;
`endif
    do_load(32'h010C_2D07);
    readout(-1, 0, 1'b0, 1'b0, s);
    n_tests++;
    if (s[15:8] !== want) begin
      n_fail++; $display("FAIL minute_byte got %h want %h", s[15:8], want);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; tick_en = 1'b0; rd_req = 1'b0; byte_ready = 1'b0;
    time_in = '0; mdl_time = 32'h0100_0000; mdl_presc = 0;
    test_reset();
    test_readout_basic();
    test_rollover();
    test_random();
    test_backpressure();
    test_load_tick_same();
    test_back_to_back();
    test_rst_mid();
    test_bcd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/time_reader.md
Name: time_reader

Overview:
- Read-side counterpart of the time-set path.
- Captures the 32-bit time word {mil, hour, minute, second} produced by the setter and keeps it running from a 1 Hz tick.
- On request, streams a coherent snapshot back out one byte at a time over a valid/ready byte interface, for display or UART framing.

Parameters:
- TICKS_PER_SEC, 1, number of tick_en pulses per counted second (1 = tick_en is already 1 Hz).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- time_in  input  32  {mil[31:24], hour[23:16], minute[15:8], second[7:0]}, binary.
- load  input  1  1-cycle pulse; capture time_in into the running counter.
- tick_en  input  1  1-cycle pulse, nominally 1 Hz.
- rd_req  input  1  start a 4-byte readout.
- byte_ready  input  1  consumer accepts byte_out this cycle.
- byte_out  output  8  current byte.
- byte_valid  output  1  byte_out is valid.
- byte_idx  output  2  0=mil, 1=hour, 2=minute, 3=second.
- busy  output  1  readout in progress.
- done  output  1  1-cycle pulse after the last byte is accepted.
- time_now  output  32  live counter value.

Behaviour:
- Reset: time_now=32'h0100_0000 (24h mode, 00:00:00); byte_out=0; byte_valid=0; byte_idx=0; busy=0; done=0; prescaler=0; FSM=IDLE.
- mil byte: bit0=1 selects 24h mode; bit1 is the PM flag (12h mode only); bits 7:2 are held unchanged.
- Prescaler:
  - Counts tick_en pulses.
  - On reaching TICKS_PER_SEC it clears and advances one second.
- Advance rules:
  - second 59 -> 0 with carry to minute.
  - minute 59 -> 0 with carry to hour.
  - 24h mode: hour 23 -> 0.
  - 12h mode: hour 12 -> 1; hour 11 -> 12 toggles PM.
  - Any field already >= its limit when it is advanced wraps exactly as its maximum does. Loaded values are not clamped.
- Latency: time_now updates on the cycle after load or a qualifying tick.
- load and tick_en in the same cycle: load wins, the tick is dropped, and the prescaler clears.
- FSM states: IDLE, SNAP, SEND, DONE.
  - IDLE: rd_req=1 -> SNAP. busy rises the following cycle.
  - SNAP: copies time_now, including any update committing this same cycle, into the shadow register; sets byte_idx=0 -> SEND.
  - SEND: byte_valid=1 and byte_out=shadow byte[byte_idx]. On byte_valid&&byte_ready: if byte_idx==3 -> DONE, else byte_idx+1 and stay in SEND.
  - byte_out and byte_idx are stable while byte_valid=1 and byte_ready=0.
  - DONE: done=1 for one cycle, busy=0, byte_valid=0 -> IDLE.
- rd_req while busy is ignored; it is not queued.
- load or tick during a readout changes only time_now, never the shadow.
- rst mid-readout: immediate return to IDLE, byte_valid=0, no done pulse.
- Minimum transaction: 6 cycles from rd_req to done with byte_ready tied high.

Optional Feature:
- Macro: TIME_READER_BCD_EN.
- Defined: each byte of byte_out is converted to packed BCD (e.g. 59 -> 8'h59). The mil byte passes through unconverted. Conversion is combinational on the shadow, so latency is unchanged.
- Undefined: bytes are sent in binary.
- time_now is binary in both cases.

Decomposition:
- Package time_pkg:
  - field offsets MIL_LSB=24, HOUR_LSB=16, MIN_LSB=8, SEC_LSB=0;
  - limits SEC_MAX=59, MIN_MAX=59, HOUR24_MAX=23, HOUR12_MAX=12;
  - mil bit indices MIL_24H=0, MIL_PM=1;
  - FSM state enum.
- Sub-module: time_advance, combinational next-second logic (32-bit in -> 32-bit out), reusable by other timekeeping blocks.
- Under TIME_READER_BCD_EN: additionally bin2bcd8.

Test Plan:
- Reset, then rd_req with byte_ready=1 -> bytes 01,00,00,00 with byte_idx 0..3; done pulses 5 cycles after the SNAP cycle.
- load 32'h0117_3B3B, one tick (TICKS_PER_SEC=1) -> time_now=32'h0100_0000 (23:59:59 -> 00:00:00).
- 12h mode: load 32'h000B_3B3B, one tick -> 32'h020C_0000. Load 32'h020C_3B3B, one tick -> 32'h0201_0000.
- Backpressure: byte_ready low for 3 cycles on byte_idx=1 -> byte_out and byte_idx held; tick during the stall -> streamed bytes still equal the snapshot.
- load and tick_en in the same cycle with time_in=32'h0105_0A14 -> time_now=32'h0105_0A14 exactly; rd_req during busy -> exactly one done pulse.
- rst asserted during SEND at byte_idx=2 -> next cycle byte_valid=0, busy=0, no done pulse, time_now=32'h0100_0000. With BCD_EN: minute 45 streams as 8'h45.
